nw_job_loader: RTL

//  Upstream feeder and result collector for the NW scoring Grid. Accepts one

---
 rtl/nw_job_loader_if.sv | 45 ++++
 rtl/nw_job_loader.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/nw_job_loader_if.sv
// nw_job_loader_if
//   Bundles the character input stream, the Grid-facing buses and the result
//   stream of the NW job loader.
//   Handshake rule (both streams): a transfer happens on a posedge where
//   valid && ready; valid, once raised, holds with its payload until that
//   transfer, and ready never depends combinationally on valid.
// Signals
//   in_valid/in_ready/in_a/in_b/in_last : character pair stream into loader
//   s1/s2/grid_valid                    : packed strings to the Grid
//   grid_score                          : Grid corner score back to loader
//   out_valid/out_ready/out_score/out_err : result stream out of loader
//   busy                                : loader not in LOAD
// Modports
//   slave  : the loader's view
//   master : the environment's view (sender, Grid and consumer)
interface nw_job_loader_if #(
    parameter int LENGTH = 10,
    parameter int CWIDTH = 2,
    parameter int SWIDTH = 16
);
    logic                       in_valid;
    logic                       in_ready;
    logic [CWIDTH-1:0]          in_a;
    logic [CWIDTH-1:0]          in_b;
    logic                       in_last;
    logic [LENGTH*CWIDTH-1:0]   s1;
    logic [LENGTH*CWIDTH-1:0]   s2;
    logic                       grid_valid;
    logic signed [SWIDTH-1:0]   grid_score;
    logic                       out_valid;
    logic                       out_ready;
    logic signed [SWIDTH-1:0]   out_score;
    logic                       out_err;
    logic                       busy;

    modport slave (
        input  in_valid, in_a, in_b, in_last, grid_score, out_ready,
        output in_ready, s1, s2, grid_valid, out_valid, out_score, out_err, busy
    );

    modport master (
        output in_valid, in_a, in_b, in_last, grid_score, out_ready,
        input  in_ready, s1, s2, grid_valid, out_valid, out_score, out_err, busy
    );
endinterface

// File: rtl/nw_job_loader.sv
// nw_job_loader
//   Feeder and result collector for the NW scoring Grid. Packs LENGTH
//   character pairs into s1/s2, holds them while the Grid wavefront settles
//   for GRID_LATENCY cycles, captures the corner score and offers it on the
//   result stream. One job in flight at a time.
// Ports
//   clk       : clock, all logic on posedge
//   rst       : synchronous active-high reset, aborts any job
//   bus       : nw_job_loader_if.slave (input stream, Grid buses, result stream)
//   dbg_state : current FSM state (0=LOAD, 1=RUN, 2=DONE)
module nw_job_loader #(
    parameter int LENGTH       = 10,
    parameter int CWIDTH       = 2,
    parameter int SWIDTH       = 16,
    parameter int GRID_LATENCY = 38
) (
    input  logic                clk,
    input  logic                rst,
    nw_job_loader_if.slave      bus,
    output logic [1:0]          dbg_state
);
    localparam int IDX_W = $clog2(LENGTH) + 1;
    localparam int CNT_W = $clog2(GRID_LATENCY) + 1;
    localparam int SV_W  = LENGTH * CWIDTH;

    typedef enum logic [1:0] {
        ST_LOAD = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t                   state_q,     state_n;
    logic [IDX_W-1:0]         idx_q,       idx_n;
    logic [CNT_W-1:0]         cnt_q,       cnt_n;
    logic [SV_W-1:0]          s1_q,        s1_n;
    logic [SV_W-1:0]          s2_q,        s2_n;
    logic                     err_flag_q,  err_flag_n;
    logic signed [SWIDTH-1:0] score_q,     score_n;
    logic                     out_err_q,   out_err_n;
    logic                     out_valid_q, out_valid_n;
    logic                     in_ready_q,  in_ready_n;
    logic                     grid_valid_q, grid_valid_n;

    logic beat;
    logic last_idx;

    // in_ready_q is only ever set in LOAD, so it alone qualifies a beat.
    assign beat     = bus.in_valid && in_ready_q;
    assign last_idx = (idx_q == IDX_W'(LENGTH - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_LOAD;
            idx_q        <= '0;
            cnt_q        <= '0;
            s1_q         <= '0;
            s2_q         <= '0;
            err_flag_q   <= 1'b0;
            score_q      <= '0;
            out_err_q    <= 1'b0;
            out_valid_q  <= 1'b0;
            in_ready_q   <= 1'b1;
            grid_valid_q <= 1'b0;
        end else begin
            state_q      <= state_n;
            idx_q        <= idx_n;
            cnt_q        <= cnt_n;
            s1_q         <= s1_n;
            s2_q         <= s2_n;
            err_flag_q   <= err_flag_n;
            score_q      <= score_n;
            out_err_q    <= out_err_n;
            out_valid_q  <= out_valid_n;
            in_ready_q   <= in_ready_n;
            grid_valid_q <= grid_valid_n;
        end
    end

    always_comb begin
        state_n      = state_q;
        idx_n        = idx_q;
        cnt_n        = cnt_q;
        s1_n         = s1_q;
        s2_n         = s2_q;
        err_flag_n   = err_flag_q;
        score_n      = score_q;
        out_err_n    = out_err_q;
        out_valid_n  = out_valid_q;
        in_ready_n   = in_ready_q;
        grid_valid_n = grid_valid_q;

        unique case (state_q)
            ST_LOAD: begin
                if (beat) begin
                    for (int i = 0; i < LENGTH; i++) begin
                        if (idx_q == IDX_W'(i)) begin
                            s1_n[i*CWIDTH +: CWIDTH] = bus.in_a;
                            s2_n[i*CWIDTH +: CWIDTH] = bus.in_b;
                        end
                    end
                    // in_last is only checked; the job is always LENGTH beats.
                    if (bus.in_last != last_idx) begin
                        err_flag_n = 1'b1;
                    end
                    if (last_idx) begin
                        state_n      = ST_RUN;
                        idx_n        = '0;
                        cnt_n        = '0;
                        in_ready_n   = 1'b0;
                        grid_valid_n = 1'b1;
                    end else begin
                        idx_n = idx_q + 1'b1;
                    end
                end
            end
            ST_RUN: begin
                cnt_n = cnt_q + 1'b1;
                // cnt==k-1 on edge T+k, so this capture lands on T+GRID_LATENCY.
                if (cnt_q == CNT_W'(GRID_LATENCY - 1)) begin
                    score_n      = bus.grid_score;
                    out_err_n    = err_flag_q;
                    out_valid_n  = 1'b1;
                    grid_valid_n = 1'b0;
                    state_n      = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_valid_q && bus.out_ready) begin
                    out_valid_n = 1'b0;
                    out_err_n   = 1'b0;
                    err_flag_n  = 1'b0;
                    in_ready_n  = 1'b1;
                    state_n     = ST_LOAD;
                end
            end
            default: begin
                state_n = ST_LOAD;
            end
        endcase
    end

    assign bus.in_ready   = in_ready_q;
    assign bus.s1         = s1_q;
    assign bus.s2         = s2_q;
    assign bus.grid_valid = grid_valid_q;
    assign bus.out_valid  = out_valid_q;
    assign bus.out_score  = score_q;
    assign bus.out_err    = out_err_q;
    assign bus.busy       = (state_q != ST_LOAD);
    assign dbg_state      = state_q;
endmodule
